// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-successor glue-logic blocks.
// Provides the default channel/address sizing and a constant-friendly clog2.
package ttl_pkg;

    localparam int TTL_CHANNELS = 2;
    localparam int TTL_ABITS    = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter width for a modulo-d counter, never narrower than one bit
    function automatic int cnt_width(input int d);
        int w;
        w = clog2(d);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ttl_scan_decoder_chan.sv
// One decoder channel: address latch, scan sequencer, one-hot
// active-low decode and bufif0-style output drivers.
module ttl_scan_decoder_chan
    import ttl_pkg::*;
#(
    parameter int ABITS = TTL_ABITS,
    parameter int DWELL = 1,
    parameter int NOUT  = 2 ** ABITS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [ABITS-1:0] a,
    input  logic             le,
    input  logic             scan,
    input  logic             e_n,
    output tri   [NOUT-1:0]  o_n,
    output logic             wrap
);

    localparam int DW = cnt_width(DWELL);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [ABITS-1:0] ADDR_LAST  = ABITS'(NOUT - 1);

    logic [ABITS-1:0] addr_q, addr_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [NOUT-1:0]  dec;

    always_comb begin
        addr_d  = addr_q;
        dwell_d = dwell_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        if (le) begin
            addr_d  = a;
            dwell_d = '0;
            valid_d = 1'b1;
        end else if (scan) begin
            valid_d = 1'b1;
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                addr_d  = addr_q + ABITS'(1);
                wrap_d  = (addr_q == ADDR_LAST);
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q  <= '0;
            dwell_q <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            dwell_q <= dwell_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // Decode is purely from registers, so A only matters when latched
    always_comb begin
        dec = '1;
        if (valid_q) dec[addr_q] = 1'b0;
    end

    assign o_n  = e_n ? {NOUT{1'bz}} : dec;
    assign wrap = wrap_q;

endmodule

// File: rtl/ttl_scan_decoder.sv
// CHANNELS independent latched/scanned ABITS-to-2^ABITS decoders
// with active-low tri-state outputs; top level only slices buses.
module ttl_scan_decoder
    import ttl_pkg::*;
#(
    parameter int CHANNELS = TTL_CHANNELS,
    parameter int ABITS    = TTL_ABITS,
    parameter int DWELL    = 1,
    parameter int NOUT     = 2 ** ABITS
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [CHANNELS*ABITS-1:0] A,
    input  logic [CHANNELS-1:0]       LE,
    input  logic [CHANNELS-1:0]       SCAN,
    input  logic [CHANNELS-1:0]       _E,
    output tri   [CHANNELS*NOUT-1:0]  _O,
    output logic [CHANNELS-1:0]       WRAP
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        ttl_scan_decoder_chan #(
            .ABITS (ABITS),
            .DWELL (DWELL),
            .NOUT  (NOUT)
        ) u_chan (
            .CLK   (CLK),
            .RESET (RESET),
            .a     (A[c*ABITS +: ABITS]),
            .le    (LE[c]),
            .scan  (SCAN[c]),
            .e_n   (_E[c]),
            .o_n   (_O[c*NOUT +: NOUT]),
            .wrap  (WRAP[c])
        );
    end

endmodule

// File: tb/tb_ttl_scan_decoder.sv
// Directed bench: a vector table on a 2-channel DWELL=1 decoder plus
// hand sequences on a 1-channel DWELL=3 decoder. Z outputs read as 1 via tri1.
module tb_ttl_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DWELL=1, two channels
    logic       rst1;
    logic [3:0] a1;
    logic [1:0] le1, scan1, en1;
    tri1  [7:0] o1;
    logic [1:0] wr1;

    // DWELL=3, one channel
    logic       rst3;
    logic [1:0] a3;
    logic       le3, scan3, en3;
    tri1  [3:0] o3;
    logic       wr3;

    ttl_scan_decoder #(.CHANNELS(2), .ABITS(2), .DWELL(1)) dut1 (
        .CLK(clk), .RESET(rst1), .A(a1), .LE(le1), .SCAN(scan1),
        ._E(en1), ._O(o1), .WRAP(wr1)
    );

    ttl_scan_decoder #(.CHANNELS(1), .ABITS(2), .DWELL(3)) dut3 (
        .CLK(clk), .RESET(rst3), .A(a3), .LE(le3), .SCAN(scan3),
        ._E(en3), ._O(o3), .WRAP(wr3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [1:0] le;
        logic [1:0] scan;
        logic [1:0] en;
        logic [7:0] o;
        logic [1:0] wr;
    } vec_t;

    vec_t tv[18];

    initial begin
        // rst, A, LE, SCAN, _E  ->  _O, WRAP (after the edge)
        tv[0]  = '{1'b1, 4'h0, 2'b00, 2'b00, 2'b00, 8'hFF, 2'b00};
        tv[1]  = '{1'b0, 4'h2, 2'b01, 2'b00, 2'b00, 8'hFB, 2'b00};
        tv[2]  = '{1'b0, 4'h1, 2'b00, 2'b00, 2'b00, 8'hFB, 2'b00};
        tv[3]  = '{1'b0, 4'h4, 2'b10, 2'b01, 2'b00, 8'hD7, 2'b00};
        tv[4]  = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b00, 8'hDE, 2'b01};
        tv[5]  = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b00, 8'hDD, 2'b00};
        tv[6]  = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b00, 8'hDB, 2'b00};
        tv[7]  = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b01, 8'hDF, 2'b00};
        tv[8]  = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b01, 8'hDF, 2'b01};
        tv[9]  = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b00, 8'hDD, 2'b00};
        tv[10] = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b10, 8'hFB, 2'b00};
        tv[11] = '{1'b0, 4'h0, 2'b01, 2'b01, 2'b00, 8'hDE, 2'b00};
        tv[12] = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b00, 8'hDD, 2'b00};
        tv[13] = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b00, 8'hDB, 2'b00};
        tv[14] = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b00, 8'hD7, 2'b00};
        tv[15] = '{1'b1, 4'h0, 2'b00, 2'b01, 2'b00, 8'hFF, 2'b00};
        tv[16] = '{1'b0, 4'h0, 2'b00, 2'b00, 2'b00, 8'hFF, 2'b00};
        tv[17] = '{1'b0, 4'h0, 2'b00, 2'b01, 2'b00, 8'hFD, 2'b00};

        rst1 = 1'b1; a1 = '0; le1 = '0; scan1 = '0; en1 = '0;
        rst3 = 1'b1; a3 = '0; le3 = 1'b0; scan3 = 1'b0; en3 = 1'b0;
        #1;

        for (int i = 0; i < 18; i++) begin
            rst1  = tv[i].rst;
            a1    = tv[i].a;
            le1   = tv[i].le;
            scan1 = tv[i].scan;
            en1   = tv[i].en;
            tick();
            chk($sformatf("vec%0d _O", i), 32'(o1), 32'(tv[i].o));
            chk($sformatf("vec%0d WRAP", i), 32'(wr1), 32'(tv[i].wr));
        end

        // DWELL=3: reset state, then latch address 0
        tick();
        chk("d3 reset _O", 32'(o3), 32'h F);
        chk("d3 reset WRAP", 32'(wr3), 32'h0);
        rst3 = 1'b0;
        le3  = 1'b1;
        a3   = 2'd0;
        tick();
        chk("d3 latch0", 32'(o3), 32'h E);
        le3   = 1'b0;
        scan3 = 1'b1;

        // each address stays selected for three edges
        begin
            logic [3:0] exp_seq [7];
            exp_seq = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hB, 4'hB};
            for (int k = 0; k < 7; k++) begin
                tick();
                chk($sformatf("d3 dwell%0d", k), 32'(o3), 32'(exp_seq[k]));
            end
        end

        // pause mid-dwell: position and dwell count are held
        scan3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("d3 pause%0d", k), 32'(o3), 32'h B);
        end
        scan3 = 1'b1;
        tick();
        chk("d3 resume last dwell", 32'(o3), 32'h B);
        tick();
        chk("d3 resume advance", 32'(o3), 32'h 7);
        tick();
        tick();
        chk("d3 addr3 late dwell", 32'(o3), 32'h 7);

        // LE beats SCAN on the edge that would have wrapped
        le3 = 1'b1;
        a3  = 2'd0;
        tick();
        chk("d3 le+scan _O", 32'(o3), 32'h E);
        chk("d3 le+scan WRAP", 32'(wr3), 32'h0);
        le3 = 1'b0;
        tick();
        tick();
        chk("d3 full dwell from 0", 32'(o3), 32'h E);
        tick();
        chk("d3 advance to 1", 32'(o3), 32'h D);

        // 12 edges from addr1: one wrap, lands back on addr1; outputs Z
        en3 = 1'b1;
        begin
            int wraps;
            wraps = 0;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (wr3) wraps++;
            end
            chk("d3 Z while scanning", 32'(o3), 32'h F);
            chk("d3 wrap count", 32'(wraps), 32'd1);
        end
        en3 = 1'b0;
        #1;
        chk("d3 advanced position", 32'(o3), 32'h D);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
